// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC/fetch block: FSM encoding, fault cause codes
// and instruction geometry.
package pc_fetch_unit_pkg;

    // S_IDLE only exists between reset release and the first fetch request.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_HOLD = 2'b11
    } fetch_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    localparam int unsigned INSTR_BYTES = 4;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_wait.sv
// Response-wait timer: counts stalled-free wait cycles and flags when the
// MAX_WAIT limit is reached. Saturates at the limit until cleared.
module pc_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (cnt_q == CW'(MAX_WAIT));

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register plus single-outstanding instruction fetch with
// hold-until-retire, misaligned-target and imem-timeout redirection.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter int unsigned          INSTR_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(32'h0000_0000),
    parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = PC_WIDTH'(32'h0000_0100),
    parameter int unsigned          MAX_WAIT     = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PC_WIDTH-1:0]    pc_next_i,
    input  logic                   advance_i,
    input  logic                   stall_i,
    output logic [PC_WIDTH-1:0]    pc_o,
    output logic [PC_WIDTH-1:0]    pc_plus_4_o,
    output logic                   imem_req_valid_o,
    input  logic                   imem_req_ready_i,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
    output logic                   imem_abort_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic                   instr_valid_o,
    output logic                   fault_o,
    output logic [1:0]             fault_cause_o,
    output logic [31:0]            retired_cnt_o
);

    fetch_state_e         state_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   req_valid_q;
    logic                   instr_valid_q;
    logic                   fault_q;
    logic                   abort_q;
    logic [1:0]             cause_q;
    logic [31:0]            retired_q;

    logic handshake;
    logic rsp_take;
    logic timeout;
    logic retire;
    logic wait_expired;

    // Stall freezes every transition, including a request the imem sees as ready.
    assign handshake = (state_q == S_REQ)  && !stall_i && imem_req_ready_i;
    assign rsp_take  = (state_q == S_WAIT) && !stall_i && imem_rsp_valid_i;
    assign timeout   = (state_q == S_WAIT) && !stall_i && !imem_rsp_valid_i && wait_expired;
    assign retire    = (state_q == S_HOLD) && !stall_i && advance_i;

    pc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (handshake),
        .enable  ((state_q == S_WAIT) && !stall_i && !imem_rsp_valid_i),
        .expired (wait_expired)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below reads the pre-edge value regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VECTOR;
            instr_q       <= '0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            abort_q       <= 1'b0;
            cause_q       <= FAULT_NONE;
            retired_q     <= '0;
        end else begin
            // NOTE: pulses default low each cycle; the branches below only
            // raise them, which keeps them single-cycle by construction.
            fault_q <= 1'b0;
            abort_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    state_q     <= S_REQ;
                    req_valid_q <= 1'b1;
                end

                S_REQ: begin
                    if (handshake) begin
                        state_q     <= S_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (rsp_take) begin
                        instr_q       <= imem_rsp_data_i;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_HOLD;
                    end else if (timeout) begin
                        abort_q     <= 1'b1;
                        fault_q     <= 1'b1;
                        cause_q     <= FAULT_TIMEOUT;
                        pc_q        <= TRAP_VECTOR;
                        req_valid_q <= 1'b1;
                        state_q     <= S_REQ;
                    end
                end

                S_HOLD: begin
                    if (retire) begin
                        retired_q     <= retired_q + 32'd1;
                        instr_valid_q <= 1'b0;
                        req_valid_q   <= 1'b1;
                        state_q       <= S_REQ;
                        if (is_misaligned(pc_next_i[1:0])) begin
                            pc_q    <= TRAP_VECTOR;
                            fault_q <= 1'b1;
                            cause_q <= FAULT_MISALIGN;
                        end else begin
                            pc_q <= pc_next_i;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pc_o             = pc_q;
    assign pc_plus_4_o      = pc_q + PC_WIDTH'(INSTR_BYTES);
    assign imem_req_valid_o = req_valid_q;
    assign imem_addr_o      = pc_q;
    assign imem_abort_o     = abort_q;
    assign instr_o          = instr_q;
    assign instr_valid_o    = instr_valid_q;
    assign fault_o          = fault_q;
    assign fault_cause_o    = cause_q;
    assign retired_cnt_o    = retired_q;

    fault_single_cycle: assert property (@(posedge clk) disable iff (!rst_n) fault_o |=> !fault_o);
    abort_single_cycle: assert property (@(posedge clk) disable iff (!rst_n) imem_abort_o |=> !imem_abort_o);

endmodule
